// File: rtl/pipes_pkg.sv
// pipes_pkg: shared pipeline types, fetch FSM states and reset PC
package pipes_pkg;
    typedef logic [63:0] word_t;
    typedef logic [31:0] inst_t;
    localparam word_t PCINIT = 64'h8000_0000;
    typedef enum logic [1:0] {FETCH, HOLD, DISCARD} fetch_state_t;
    typedef struct packed {
        logic  valid;
        inst_t instr;
        word_t pc;
    } decode_data_t;
    function automatic word_t align4(input word_t a);
        return {a[63:2], 2'b00};
    endfunction
endpackage

// File: rtl/fetch_skid.sv
// fetch_skid: one-entry buffer catching a response that arrives while decode is stalled
module fetch_skid
    import pipes_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] in_instr,
    input  logic [63:0] in_pc,
    output logic        full,
    output logic [31:0] instr,
    output logic [63:0] pc
);
    decode_data_t q;
    assign full  = q.valid;
    assign instr = q.instr;
    assign pc    = q.pc;
    // clear wins over load so a redirect always empties the entry
    always_ff @(posedge clk) begin
        if (reset || clear) q <= '0;
        else if (load) q <= '{1'b1, in_instr, in_pc};
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch with one-deep skid, redirect and stale-response discard
module fetch_unit
    import pipes_pkg::*;
#(
    parameter word_t PCINIT = pipes_pkg::PCINIT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        stall,
    input  logic        branch,
    input  logic [63:0] branch_target,
    output logic        valid,
    output logic [31:0] instr,
    output logic [63:0] pc,
    output logic        stopf
);
    fetch_state_t state, state_n;
    word_t        fpc, fpc_n, tgt, tgt_n;
    decode_data_t slot, slot_n;
    logic         skid_load, skid_clear, skid_full, take, pending, wait_resp;
    logic [31:0]  skid_instr;
    word_t        skid_pc;

    assign take       = slot.valid & ~stall;
    assign pending    = state != HOLD;
    assign wait_resp  = pending & ~iresp_data_ok;
    assign ireq_valid = pending & ~reset;
    assign ireq_addr  = fpc;
    assign valid      = slot.valid;
    assign instr      = slot.instr;
    assign pc         = slot.pc;
    assign stopf      = ~slot.valid;

    fetch_skid u_skid (
        .clk     (clk),
        .reset   (reset),
        .load    (skid_load),
        .clear   (skid_clear),
        .in_instr(iresp_data),
        .in_pc   (fpc),
        .full    (skid_full),
        .instr   (skid_instr),
        .pc      (skid_pc)
    );

    // next state: redirect first, then per-state response/handoff handling
    always_comb begin
        state_n    = state;
        fpc_n      = fpc;
        tgt_n      = tgt;
        slot_n     = slot;
        slot_n.valid = slot.valid & ~take;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        if (branch) begin
            slot_n.valid = 1'b0;
            skid_clear   = 1'b1;
            tgt_n        = align4(branch_target);
            state_n      = wait_resp ? DISCARD : FETCH;
            fpc_n        = wait_resp ? fpc : align4(branch_target);
        end else begin
            case (state)
                FETCH: begin
                    if (iresp_data_ok) begin
                        fpc_n = fpc + 64'd4;
                        if (slot.valid && stall) begin
                            skid_load = 1'b1;
                            state_n   = HOLD;
                        end else begin
                            slot_n = '{1'b1, iresp_data, fpc};
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        slot_n     = '{skid_full, skid_instr, skid_pc};
                        skid_clear = 1'b1;
                        state_n    = FETCH;
                    end
                end
                DISCARD: begin
                    if (iresp_data_ok) begin
                        fpc_n   = tgt;
                        state_n = FETCH;
                    end
                end
                default: state_n = FETCH;
            endcase
        end
    end

    // state, fetch PC, held redirect target and decode slot registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            fpc   <= PCINIT;
            tgt   <= PCINIT;
            slot  <= '0;
        end else begin
            state <= state_n;
            fpc   <= fpc_n;
            tgt   <= tgt_n;
            slot  <= slot_n;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table plus randomized run against a stream model
module tb_fetch_unit;
    localparam logic [63:0] P = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok = 1'b0;
    logic [31:0] iresp_data = '0;
    logic        stall = 1'b0;
    logic        branch = 1'b0;
    logic [63:0] branch_target = '0;
    logic        valid;
    logic [31:0] instr;
    logic [63:0] pc;
    logic        stopf;

    always #5 clk = ~clk;

    fetch_unit #(.PCINIT(P)) dut (
        .clk          (clk),
        .reset        (reset),
        .ireq_valid   (ireq_valid),
        .ireq_addr    (ireq_addr),
        .iresp_data_ok(iresp_data_ok),
        .iresp_data   (iresp_data),
        .stall        (stall),
        .branch       (branch),
        .branch_target(branch_target),
        .valid        (valid),
        .instr        (instr),
        .pc           (pc),
        .stopf        (stopf)
    );

    typedef struct {
        logic        rst, dok, st, br;
        logic [63:0] bt;
        logic        eiv;
        logic [63:0] ea;
        logic        ev;
        logic [63:0] epc;
    } vec_t;

    vec_t vec[40];
    int   n_chk = 0;
    int   n_fail = 0;
    int   handoffs = 0;
    logic [63:0] exp_pc, prev_addr;
    logic        prev_wait;

    function automatic logic [31:0] d(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_1234;
    endfunction

    function automatic vec_t mk(input logic r, dk, s, b, input logic [63:0] bt,
                                input logic eiv, input logic [63:0] ea,
                                input logic ev, input logic [63:0] epc);
        vec_t v;
        v.rst = r; v.dok = dk; v.st = s; v.br = b; v.bt = bt;
        v.eiv = eiv; v.ea = ea; v.ev = ev; v.epc = epc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        vec[0]  = mk(0,1,0,0,0,                     1,P,          0,0);
        vec[1]  = mk(0,1,0,0,0,                     1,P+4,        1,P);
        vec[2]  = mk(0,1,0,0,0,                     1,P+8,        1,P+4);
        vec[3]  = mk(1,1,0,0,0,                     0,P+'hC,      1,P+8);
        vec[4]  = mk(0,1,0,0,0,                     1,P,          0,0);
        vec[5]  = mk(0,1,1,0,0,                     1,P+4,        1,P);
        vec[6]  = mk(0,0,1,0,0,                     0,P+8,        1,P);
        vec[7]  = mk(0,0,1,0,0,                     0,P+8,        1,P);
        vec[8]  = mk(0,0,0,0,0,                     0,P+8,        1,P);
        vec[9]  = mk(0,1,0,0,0,                     1,P+8,        1,P+4);
        vec[10] = mk(0,1,0,0,0,                     1,P+'hC,      1,P+8);
        vec[11] = mk(0,0,0,0,0,                     1,P+'h10,     1,P+'hC);
        vec[12] = mk(0,0,0,1,P+'h100,               1,P+'h10,     0,0);
        vec[13] = mk(0,0,0,0,0,                     1,P+'h10,     0,0);
        vec[14] = mk(0,0,0,0,0,                     1,P+'h10,     0,0);
        vec[15] = mk(0,1,0,0,0,                     1,P+'h10,     0,0);
        vec[16] = mk(0,1,0,0,0,                     1,P+'h100,    0,0);
        vec[17] = mk(0,0,0,0,0,                     1,P+'h104,    1,P+'h100);
        vec[18] = mk(0,1,0,1,P+'h203,               1,P+'h104,    0,0);
        vec[19] = mk(0,0,0,0,0,                     1,P+'h200,    0,0);
        vec[20] = mk(0,1,0,0,0,                     1,P+'h200,    0,0);
        vec[21] = mk(0,0,0,0,0,                     1,P+'h204,    1,P+'h200);
        vec[22] = mk(0,0,0,1,P+'h300,               1,P+'h204,    0,0);
        vec[23] = mk(0,0,0,1,P+'h400,               1,P+'h204,    0,0);
        vec[24] = mk(0,1,0,0,0,                     1,P+'h204,    0,0);
        vec[25] = mk(0,1,0,0,0,                     1,P+'h400,    0,0);
        vec[26] = mk(0,0,1,0,0,                     1,P+'h404,    1,P+'h400);
        vec[27] = mk(0,0,0,0,0,                     1,P+'h404,    1,P+'h400);
        vec[28] = mk(0,1,1,0,0,                     1,P+'h404,    0,0);
        vec[29] = mk(0,1,1,0,0,                     1,P+'h408,    1,P+'h404);
        vec[30] = mk(0,0,1,0,0,                     0,P+'h40C,    1,P+'h404);
        vec[31] = mk(1,0,1,0,0,                     0,P+'h40C,    1,P+'h404);
        vec[32] = mk(0,0,0,0,0,                     1,P,          0,0);
        vec[33] = mk(0,1,0,0,0,                     1,P,          0,0);
        vec[34] = mk(0,0,1,0,0,                     1,P+4,        1,P);
        vec[35] = mk(0,0,0,1,64'hFFFF_FFFF_FFFF_FFFE,1,P+4,       1,P);
        vec[36] = mk(0,1,0,0,0,                     1,P+4,        0,0);
        vec[37] = mk(0,1,0,0,0,                     1,64'hFFFF_FFFF_FFFF_FFFC,0,0);
        vec[38] = mk(0,1,0,0,0,                     1,64'h0,      1,64'hFFFF_FFFF_FFFF_FFFC);
        vec[39] = mk(0,0,0,0,0,                     1,64'h4,      1,64'h0);

        reset = 1'b1;
        iresp_data_ok = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset ireq_valid", ireq_valid, 0);
        chk("reset ireq_addr", ireq_addr, P);
        chk("reset valid", valid, 0);
        chk("reset pc", pc, 0);
        chk("reset instr", instr, 0);
        chk("reset stopf", stopf, 1);

        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            reset = vec[i].rst;
            iresp_data_ok = vec[i].dok;
            iresp_data = vec[i].dok ? d(vec[i].ea) : 32'hDEAD_BEEF;
            stall = vec[i].st;
            branch = vec[i].br;
            branch_target = vec[i].bt;
            #1;
            chk($sformatf("row%0d ireq_valid", i), ireq_valid, vec[i].eiv);
            chk($sformatf("row%0d ireq_addr", i), ireq_addr, vec[i].ea);
            chk($sformatf("row%0d valid", i), valid, vec[i].ev);
            chk($sformatf("row%0d stopf", i), stopf, !vec[i].ev);
            if (vec[i].ev) begin
                chk($sformatf("row%0d pc", i), pc, vec[i].epc);
                chk($sformatf("row%0d instr", i), instr, d(vec[i].epc));
            end
        end

        @(negedge clk);
        reset = 1'b1;
        iresp_data_ok = 1'b0;
        branch = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        exp_pc = P;
        prev_wait = 1'b0;
        prev_addr = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 99) == 0);
            #1;
            if (prev_wait) chk("rnd addr_stable", ireq_addr, prev_addr);
            chk("rnd stopf", stopf, !valid);
            iresp_data_ok = ireq_valid && ($urandom_range(0, 2) != 0);
            iresp_data = iresp_data_ok ? d(ireq_addr) : $urandom;
            stall = ($urandom_range(0, 2) == 0);
            branch = ($urandom_range(0, 15) == 0);
            branch_target = {32'h0, 32'h8000_0000 | 32'($urandom_range(0, 4095))};
            if (!reset && valid && !stall) begin
                chk("rnd pc", pc, exp_pc);
                chk("rnd instr", instr, d(exp_pc));
                exp_pc = exp_pc + 64'd4;
                handoffs++;
            end
            if (branch) exp_pc = {branch_target[63:2], 2'b00};
            if (reset) exp_pc = P;
            prev_wait = ireq_valid && !iresp_data_ok && !reset;
            prev_addr = ireq_addr;
        end
        chk("rnd progress", handoffs >= 300, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
